seven_seg_scanner: RTL

Self-refreshing multiplexed seven-segment display controller, the parametrised successor to the single-digit, externally-selected decoder.
- Owns the digit scan counter and takes all digit values in parallel.
- Adds per-digit decimal points and digit enables, leading-zero blanking, per-digit blink, 16-level PWM brightness and optional hex decode.
- Sits between the stopwatch datapath and the board anode/cathode pins.

---
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner. It refreshes one digit per slot and
// supports leading-zero blanking, per-digit blink, PWM brightness and optional hex decode.
module seven_seg_scanner #(
  parameter int DIGIT_COUNT  = 8,
  parameter int REFRESH_DIV  = 16384,
  parameter int BLINK_FRAMES = 64,
  parameter bit HEX_MODE     = 1'b0,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                     clkIn,
  input  logic                     rstIn,
  input  logic [4*DIGIT_COUNT-1:0] bcdIn,
  input  logic [DIGIT_COUNT-1:0]   dpIn,
  input  logic [DIGIT_COUNT-1:0]   digitEnIn,
  input  logic                     blankLzIn,
  input  logic [DIGIT_COUNT-1:0]   blinkMaskIn,
  input  logic [3:0]               brightIn,
  output logic [DIGIT_COUNT-1:0]   aSegOut,
  output logic [7:0]               cSegOut,
  output logic                     frameOut
);

  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int ON_W    = DIV_W + 1;
  localparam int IDX_W   = $clog2(DIGIT_COUNT);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STEP    = REFRESH_DIV / 16;

  logic [DIV_W-1:0]       div_cnt_reg;
  logic [IDX_W-1:0]       digit_idx_reg;
  logic [FRAME_W-1:0]     frame_cnt_reg;
  logic                   blink_phase_reg;
  logic                   frame_reg;
  logic                   lit_reg;
  logic [3:0]             bright_reg;
  logic [DIGIT_COUNT-1:0] aseg_reg;
  logic [7:0]             cseg_reg;

  logic [3:0]             nib [DIGIT_COUNT];
  logic [DIGIT_COUNT-1:0] upper_zero;

  logic                   slot_end;
  logic                   frame_wrap;
  logic [IDX_W-1:0]       idx_next;
  logic [3:0]             nib_next;
  logic                   lz_next;
  logic                   dark_next;
  logic                   lit_next;
  logic [6:0]             dec_next;
  logic [7:0]             pat_next;
  logic [ON_W-1:0]        on_len;
  logic [ON_W-1:0]        cnt_plus;

  // upper_zero[n] is set when nibbles n..DIGIT_COUNT-1 are all zero.
  generate
    for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_nib
      assign nib[gi] = bcdIn[4*gi+3:4*gi];
      if (gi == DIGIT_COUNT - 1) begin : g_top
        assign upper_zero[gi] = (nib[gi] == 4'd0);
      end else begin : g_rest
        assign upper_zero[gi] = (nib[gi] == 4'd0) && upper_zero[gi+1];
      end
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1100111;
      4'hA: s = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: s = HEX_MODE ? 7'b1111100 : 7'b0000000;
      4'hC: s = HEX_MODE ? 7'b0111001 : 7'b0000000;
      4'hD: s = HEX_MODE ? 7'b1011110 : 7'b0000000;
      4'hE: s = HEX_MODE ? 7'b1111001 : 7'b0000000;
      default: s = HEX_MODE ? 7'b1110001 : 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end   = (div_cnt_reg == DIV_W'(REFRESH_DIV - 1));
    frame_wrap = slot_end && (digit_idx_reg == IDX_W'(DIGIT_COUNT - 1));
    idx_next   = (digit_idx_reg == IDX_W'(DIGIT_COUNT - 1)) ? '0 : digit_idx_reg + 1'b1;
    nib_next   = nib[idx_next];
    lz_next    = blankLzIn && (idx_next != '0) && upper_zero[idx_next];
    dark_next  = !digitEnIn[idx_next] || (blinkMaskIn[idx_next] && blink_phase_reg);
    lit_next   = !dark_next && (!lz_next || dpIn[idx_next]);
    dec_next   = lz_next ? 7'b0000000 : decode(nib_next);
    // Dark slots also drop the cathodes so nothing ghosts onto the pins.
    pat_next   = lit_next ? {dpIn[idx_next], dec_next} : 8'h00;
    on_len     = (ON_W'(bright_reg) + ON_W'(1)) * ON_W'(STEP);
    cnt_plus   = ON_W'(div_cnt_reg) + ON_W'(1);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      div_cnt_reg     <= '0;
      digit_idx_reg   <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      frame_reg       <= 1'b0;
      lit_reg         <= 1'b0;
      bright_reg      <= 4'd0;
      aseg_reg        <= {DIGIT_COUNT{ACTIVE_LOW}};
      cseg_reg        <= {8{ACTIVE_LOW}};
    end else begin
      frame_reg <= frame_wrap;
      if (slot_end) begin
        div_cnt_reg   <= '0;
        digit_idx_reg <= idx_next;
        lit_reg       <= lit_next;
        bright_reg    <= brightIn;
        cseg_reg      <= pat_next ^ {8{ACTIVE_LOW}};
        aseg_reg      <= (lit_next ? (DIGIT_COUNT'(1) << idx_next) : '0)
                         ^ {DIGIT_COUNT{ACTIVE_LOW}};
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
        aseg_reg    <= ((lit_reg && (cnt_plus < on_len)) ? (DIGIT_COUNT'(1) << digit_idx_reg) : '0)
                       ^ {DIGIT_COUNT{ACTIVE_LOW}};
      end
      if (frame_wrap) begin
        if (frame_cnt_reg == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign aSegOut  = aseg_reg;
  assign cSegOut  = cseg_reg;
  assign frameOut = frame_reg;

endmodule
